bird_motion_ctrl: RTL and testbench

BIRD_MOTION_CTRL -- requirements
Module: bird_motion_ctrl

---
 rtl/bird_pkg.sv | 20 ++
 rtl/rise_detect.sv | 22 ++
 rtl/bird_motion_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared types and default geometry/physics constants for the bird block.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } bird_state_t;

  localparam int H_ACTIVE_DEF     = 640;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int HMAX_DEF         = 800;
  localparam int VMAX_DEF         = 525;
  localparam int BIRD_X_DEF       = 160;
  localparam int BIRD_SIZE_DEF    = 16;
  localparam int GRAVITY_DEF      = 1;
  localparam int FLAP_IMPULSE_DEF = 8;
  localparam int VEL_MAX_DEF      = 10;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge detector: compares the input against its
// previous-cycle sample, so a held-high level yields one event.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Previous-cycle sample of the input.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird game controller: IDLE/RUN/DEAD state machine, per-frame gravity and
// flap physics with ceiling/floor handling, and a registered bird sprite mask.
module bird_motion_ctrl
  import bird_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int HMAX         = HMAX_DEF,
  parameter int VMAX         = VMAX_DEF,
  parameter int BIRD_X       = BIRD_X_DEF,
  parameter int BIRD_SIZE    = BIRD_SIZE_DEF,
  parameter int GRAVITY      = GRAVITY_DEF,
  parameter int FLAP_IMPULSE = FLAP_IMPULSE_DEF,
  parameter int VEL_MAX      = VEL_MAX_DEF
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset,
  input  logic                         i_Frame_Tick,
  input  logic                         i_Start,
  input  logic                         i_Flap,
  input  logic                         i_Collide,
  input  logic [$clog2(HMAX)-1:0]      i_H_Count,
  input  logic [$clog2(VMAX)-1:0]      i_V_Count,
  output logic                         o_Draw_Bird,
  output logic [$clog2(V_ACTIVE)-1:0]  o_Bird_Y,
  output bird_state_t                  o_State,
  output logic                         o_Dead,
  output logic [7:0]                   o_Flap_Count
);

  localparam int YW = $clog2(V_ACTIVE);
  // Two extra bits: one for sign, one so Y + velocity cannot wrap.
  localparam int SW = YW + 2;

  localparam logic [YW-1:0]        Y_START   = YW'((V_ACTIVE - BIRD_SIZE) / 2);
  localparam logic signed [SW-1:0] FLOOR_S   = SW'(V_ACTIVE - BIRD_SIZE);
  localparam logic signed [SW-1:0] GRAV_S    = SW'(GRAVITY);
  localparam logic signed [SW-1:0] VEL_MAX_S = SW'(VEL_MAX);
  localparam logic signed [SW-1:0] FLAP_S    = -(SW'(FLAP_IMPULSE));

  bird_state_t             state, state_n;
  logic [YW-1:0]           y, y_n;
  logic signed [SW-1:0]    vel, vel_n;
  logic                    pending, pending_n;
  logic [7:0]              flap_cnt, flap_cnt_n;
  logic                    draw_n;

  logic                    start_rise, flap_rise;
  logic                    flap_req;
  logic signed [SW-1:0]    vel_inc, vel_new, y_sum;
  logic [31:0]             h32, v32, y32;

  rise_detect u_start_rise (
    .clk  (i_Clk),
    .rst  (i_Reset),
    .d    (i_Start),
    .rise (start_rise)
  );

  rise_detect u_flap_rise (
    .clk  (i_Clk),
    .rst  (i_Reset),
    .d    (i_Flap),
    .rise (flap_rise)
  );

  // A flap edge arriving in the same cycle as the tick is applied on that tick.
  assign flap_req = pending | flap_rise;
  assign vel_inc  = vel + GRAV_S;
  assign vel_new  = flap_req ? FLAP_S : ((vel_inc > VEL_MAX_S) ? VEL_MAX_S : vel_inc);
  assign y_sum    = $signed({2'b00, y}) + vel_new;

  // Game state register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state and physics update.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    y_n        = y;
    vel_n      = vel;
    pending_n  = pending;
    flap_cnt_n = flap_cnt;
    unique case (state)
      IDLE: begin
        if (start_rise) begin
          state_n    = RUN;
          vel_n      = '0;
          pending_n  = 1'b0;
          flap_cnt_n = '0;
        end
      end
      RUN: begin
        if (i_Collide) begin
          state_n = DEAD;
        end else if (i_Frame_Tick) begin
          if (flap_req) begin
            pending_n  = 1'b0;
            flap_cnt_n = (flap_cnt == 8'hFF) ? flap_cnt : flap_cnt + 8'd1;
          end
          if (y_sum[SW-1]) begin
            y_n   = '0;
            vel_n = '0;
          end else if (y_sum >= FLOOR_S) begin
            y_n     = FLOOR_S[YW-1:0];
            vel_n   = vel_new;
            state_n = DEAD;
          end else begin
            y_n   = y_sum[YW-1:0];
            vel_n = vel_new;
          end
        end else if (flap_rise) begin
          pending_n = 1'b1;
        end
      end
      DEAD: begin
        if (start_rise) begin
          state_n   = IDLE;
          y_n       = Y_START;
          vel_n     = '0;
          pending_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sprite hit test on the current pixel, registered below.
  assign h32 = 32'(i_H_Count);
  assign v32 = 32'(i_V_Count);
  assign y32 = 32'(y);

  always_comb begin
    draw_n = (h32 >= BIRD_X) && (h32 < BIRD_X + BIRD_SIZE) && (h32 < H_ACTIVE) &&
             (v32 >= y32)    && (v32 < y32 + BIRD_SIZE)    && (v32 < V_ACTIVE);
  end

  // Datapath registers: position, velocity, flap bookkeeping, sprite mask.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      y        <= Y_START;
      vel      <= '0;
      pending  <= 1'b0;
      flap_cnt <= '0;
      o_Draw_Bird <= 1'b0;
    end else begin
      y        <= y_n;
      vel      <= vel_n;
      pending  <= pending_n;
      flap_cnt <= flap_cnt_n;
      o_Draw_Bird <= draw_n;
    end
  end

  assign o_Bird_Y     = y;
  assign o_State      = state;
  assign o_Dead       = (state == DEAD);
  assign o_Flap_Count = flap_cnt;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl with hand-computed expected values.
module tb_bird_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       flap = 1'b0;
  logic       collide = 1'b0;
  logic [9:0] h_cnt = '0;
  logic [9:0] v_cnt = '0;
  logic       draw;
  logic [8:0] bird_y;
  logic [1:0] state;
  logic       dead;
  logic [7:0] flap_count;

  int n_cmp = 0;
  int n_bad = 0;

  bird_motion_ctrl dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Frame_Tick (tick),
    .i_Start      (start),
    .i_Flap       (flap),
    .i_Collide    (collide),
    .i_H_Count    (h_cnt),
    .i_V_Count    (v_cnt),
    .o_Draw_Bird  (draw),
    .o_Bird_Y     (bird_y),
    .o_State      (state),
    .o_Dead       (dead),
    .o_Flap_Count (flap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each pulse is driven for one full clock, sampled at the following negedge.
  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_flap();
    @(negedge clk); flap = 1'b1;
    @(negedge clk); flap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  int px_h [8] = '{160, 175, 167, 159, 176, 167, 167, 0};
  int px_v [8] = '{232, 247, 240, 240, 240, 231, 248, 0};
  int px_e [8] = '{1,   1,   1,   0,   0,   0,   0,   0};

  initial begin
    // Reset state, checked before any clock edge to see the async action.
    #2 rst = 1'b1;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_y", 32'(bird_y), 232);
    check("rst_flap_cnt", 32'(flap_count), 0);
    check("rst_dead", 32'(dead), 0);
    check("rst_draw", 32'(draw), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // Sprite mask: one-cycle latency, window H 160..175, V 232..247.
    @(negedge clk); h_cnt = 10'd160; v_cnt = 10'd232;
    #1 check("draw_latency", 32'(draw), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      h_cnt = 10'(px_h[i]);
      v_cnt = 10'(px_v[i]);
      @(negedge clk);
      check($sformatf("draw_px_%0d_%0d", px_h[i], px_v[i]), 32'(draw), 32'(px_e[i]));
    end

    // Flap in IDLE is ignored; start enters RUN; gravity 1,2,3.
    pulse_flap();
    pulse_start();
    check("start_state", 32'(state), 1);
    check("start_flap_cnt", 32'(flap_count), 0);
    pulse_tick(); check("grav_y1", 32'(bird_y), 233);
    pulse_tick(); check("grav_y2", 32'(bird_y), 235);
    pulse_tick(); check("grav_y3", 32'(bird_y), 238);

    // Two flap edges before one tick count as a single flap.
    pulse_flap();
    pulse_flap();
    check("flap_no_move", 32'(bird_y), 238);
    pulse_tick();
    check("flap_y", 32'(bird_y), 230);
    check("flap_cnt1", 32'(flap_count), 1);
    pulse_tick();
    check("flap_next_y", 32'(bird_y), 223);
    check("flap_cnt_hold", 32'(flap_count), 1);

    // Free fall from 232: 457 after 27 ticks, floor clamp at 464 on tick 28.
    do_reset();
    pulse_start();
    for (int i = 0; i < 27; i++) pulse_tick();
    check("fall_y27", 32'(bird_y), 457);
    check("fall_dead27", 32'(dead), 0);
    pulse_tick();
    check("floor_y", 32'(bird_y), 464);
    check("floor_dead", 32'(dead), 1);
    check("floor_state", 32'(state), 2);
    pulse_flap();
    for (int i = 0; i < 3; i++) pulse_tick();
    check("dead_freeze_y", 32'(bird_y), 464);
    check("dead_flap_cnt", 32'(flap_count), 0);
    pulse_start();
    check("restart_state", 32'(state), 0);
    check("restart_y", 32'(bird_y), 232);
    check("restart_dead", 32'(dead), 0);

    // Flap before every tick: 232 - 8*k reaches 0 at k = 29, then holds.
    pulse_start();
    for (int i = 0; i < 28; i++) begin pulse_flap(); pulse_tick(); end
    check("ceil_y28", 32'(bird_y), 8);
    pulse_flap(); pulse_tick();
    check("ceil_y29", 32'(bird_y), 0);
    for (int i = 0; i < 2; i++) begin pulse_flap(); pulse_tick(); end
    check("ceil_hold_y", 32'(bird_y), 0);
    check("ceil_state", 32'(state), 1);
    check("ceil_flap_cnt", 32'(flap_count), 31);
    pulse_tick();
    check("ceil_grav_y", 32'(bird_y), 1);

    // Reach Y=240: 5 gravity ticks (247), 3 flaps (223), 17 gravity ticks.
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) pulse_tick();
    check("path_y5", 32'(bird_y), 247);
    for (int i = 0; i < 3; i++) begin pulse_flap(); pulse_tick(); end
    check("path_y_flaps", 32'(bird_y), 223);
    for (int i = 0; i < 17; i++) pulse_tick();
    check("path_y240", 32'(bird_y), 240);

    // Collision coinciding with a tick wins and Y stays put.
    @(negedge clk); collide = 1'b1; tick = 1'b1;
    @(negedge clk); collide = 1'b0; tick = 1'b0;
    check("collide_state", 32'(state), 2);
    check("collide_y", 32'(bird_y), 240);
    check("collide_dead", 32'(dead), 1);

    // Back to RUN, move once, then an asynchronous reset mid-game.
    pulse_start();
    pulse_start();
    check("rerun_state", 32'(state), 1);
    pulse_tick();
    check("rerun_y", 32'(bird_y), 233);
    @(negedge clk); rst = 1'b1;
    #1;
    check("midrst_state", 32'(state), 0);
    check("midrst_y", 32'(bird_y), 232);
    @(negedge clk); rst = 1'b0;
    pulse_start();
    pulse_tick();
    check("post_rst_y", 32'(bird_y), 233);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
